// File: rtl/seq_detector_param_pkg.sv
// Shared types and width limits for the serial pattern detector.
// Includes an elaboration-time check on the pattern width.
package seqdet_pkg;

    typedef enum logic {
        SEQDET_NONOVL = 1'b0,
        SEQDET_OVL    = 1'b1
    } seqdet_mode_t;

    localparam int SEQDET_MAX_W = 32;
    localparam int SEQDET_MIN_W = 2;

    function automatic bit seqdet_w_ok(input int w);
        return (w >= SEQDET_MIN_W) && (w <= SEQDET_MAX_W);
    endfunction

    function automatic int seqdet_fill_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_window.sv
// Shift window and saturating fill counter for the detector.
// The next-state values are exported so the top can compare ahead of the edge.
module seqdet_window
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int FW    = seqdet_fill_w(PAT_W)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             flush,
    output logic [PAT_W-1:0] nhist,
    output logic [FW-1:0]    nfill
);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;

    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

    always_comb begin
        nhist = {hist_q[PAT_W-2:0], bit_in};
        nfill = fill_q;
        if (fill_q != FILL_MAX) begin
            nfill = fill_q + 1'b1;
        end
    end

    // flush only drops the fill count; stale bits are harmless once fill is 0
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (shift_en) begin
            hist_d = nhist;
            fill_d = nfill;
        end
        if (flush) begin
            fill_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with registered match pulse.
// Optional saturating match counter built when SEQDET_COUNT_EN is defined.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter int                OVERLAP = 1,
    parameter int                CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             i,
    input  logic             count_clr,
    output logic             out
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int FW = seqdet_fill_w(PAT_W);
    localparam seqdet_mode_t MODE = (OVERLAP != 0) ? SEQDET_OVL
                                                   : SEQDET_NONOVL;
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

    if (!seqdet_w_ok(PAT_W)) begin : g_bad_w
        $fatal(1, "seq_detector_param: PAT_W out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $fatal(1, "seq_detector_param: CNT_W must be positive");
    end

    logic [PAT_W-1:0] nhist;
    logic [FW-1:0]    nfill;
    logic             match;
    logic             flush;
    logic             out_q;
    logic             out_d;

    seqdet_window #(
        .PAT_W (PAT_W),
        .FW    (FW)
    ) u_window (
        .clock    (clock),
        .reset    (reset),
        .shift_en (in_valid),
        .bit_in   (i),
        .flush    (flush),
        .nhist    (nhist),
        .nfill    (nfill)
    );

    always_comb begin
        match = in_valid && (nfill == FILL_MAX) && (nhist == PATTERN);
        flush = match && (MODE == SEQDET_NONOVL);
        out_d = match;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clear beats a same-cycle match
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlap, non-overlap, short pattern.
// Three instances share one input stream; counter checks follow SEQDET_COUNT_EN.
module tb_seq_detector_param;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic i = 1'b0;
    logic count_clr = 1'b0;
    logic out1;
    logic out0;
    logic out2;
    int   ncmp = 0;
    int   nerr = 0;

`ifdef SEQDET_COUNT_EN
    logic [7:0] cnt1;
    logic [7:0] cnt0;
    logic [1:0] cnt2;
`endif

    always #5 clock = ~clock;

    seq_detector_param #(
        .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)
    ) d1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .i(i),
        .count_clr(count_clr), .out(out1)
`ifdef SEQDET_COUNT_EN
        , .match_count(cnt1)
`endif
    );

    seq_detector_param #(
        .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)
    ) d0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .i(i),
        .count_clr(count_clr), .out(out0)
`ifdef SEQDET_COUNT_EN
        , .match_count(cnt0)
`endif
    );

    seq_detector_param #(
        .PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)
    ) d2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .i(i),
        .count_clr(count_clr), .out(out2)
`ifdef SEQDET_COUNT_EN
        , .match_count(cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b,
                        input logic clr, input logic rst);
        @(negedge clock);
        in_valid  = v;
        i         = b;
        count_clr = clr;
        reset     = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic outs(input string tag, input logic e1,
                        input logic e0, input logic e2);
        chk({tag, ".out1"}, 32'(out1), 32'(e1));
        chk({tag, ".out0"}, 32'(out0), 32'(e0));
        chk({tag, ".out2"}, 32'(out2), 32'(e2));
    endtask

    task automatic cnts(input string tag, input int e1,
                        input int e0, input int e2);
`ifdef SEQDET_COUNT_EN
        chk({tag, ".cnt1"}, 32'(cnt1), 32'(e1));
        chk({tag, ".cnt0"}, 32'(cnt0), 32'(e0));
        chk({tag, ".cnt2"}, 32'(cnt2), 32'(e2));
`else
        if (tag.len() == 0) $display("%0d %0d %0d", e1, e0, e2);
`endif
    endtask

    initial begin
        // reset state
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        outs("rst", 0, 0, 0);
        cnts("rst", 0, 0, 0);

        // stream 1,0,1,1,0,1,1
        step(1, 1, 0, 0); outs("s1", 0, 0, 0);
        step(1, 0, 0, 0); outs("s2", 0, 0, 0);
        step(1, 1, 0, 0); outs("s3", 0, 0, 0);
        step(1, 1, 0, 0); outs("s4", 1, 1, 1);
        cnts("s4", 1, 1, 1);
        step(1, 0, 0, 0); outs("s5", 0, 0, 0);
        step(1, 1, 0, 0); outs("s6", 0, 0, 0);
        step(1, 1, 0, 0); outs("s7", 1, 0, 1);
        cnts("s7", 2, 1, 2);

        // idle gaps inside a pattern
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); outs("g1", 0, 0, 0);
        step(1, 0, 0, 0); outs("g2", 0, 0, 0);
        step(0, 1, 0, 0); outs("gi1", 0, 0, 0);
        step(0, 1, 0, 0); outs("gi2", 0, 0, 0);
        step(0, 1, 0, 0); outs("gi3", 0, 0, 0);
        step(1, 1, 0, 0); outs("g3", 0, 0, 0);
        step(1, 1, 0, 0); outs("g4", 1, 1, 1);
        step(0, 1, 0, 0); outs("g5", 0, 0, 0);
        cnts("g5", 1, 1, 1);

        // reset on the completing bit
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); outs("r1", 0, 0, 0);
        step(1, 0, 0, 0); outs("r2", 0, 0, 0);
        step(1, 1, 0, 0); outs("r3", 0, 0, 0);
        step(1, 1, 0, 1); outs("rr", 0, 0, 0);
        cnts("rr", 0, 0, 0);
        step(1, 1, 0, 0); outs("r4", 0, 0, 0);
        step(1, 0, 0, 0); outs("r5", 0, 0, 0);
        step(1, 1, 0, 0); outs("r6", 0, 0, 0);
        step(1, 1, 0, 0); outs("r7", 1, 1, 1);
        cnts("r7", 1, 1, 1);

        // clear coinciding with a match
        step(1, 0, 0, 0); outs("c1", 0, 0, 0);
        step(1, 1, 0, 0); outs("c2", 0, 0, 0);
        step(1, 1, 1, 0); outs("c3", 1, 0, 1);
        cnts("c3", 0, 0, 0);

        // all ones on the 2-bit detector, 2-bit counter saturates
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); outs("o1", 0, 0, 0); cnts("o1", 0, 0, 0);
        step(1, 1, 0, 0); outs("o2", 0, 0, 1); cnts("o2", 0, 0, 1);
        step(1, 1, 0, 0); outs("o3", 0, 0, 1); cnts("o3", 0, 0, 2);
        step(1, 1, 0, 0); outs("o4", 0, 0, 1); cnts("o4", 0, 0, 3);
        step(1, 1, 0, 0); outs("o5", 0, 0, 1); cnts("o5", 0, 0, 3);
        step(1, 1, 0, 0); outs("o6", 0, 0, 1); cnts("o6", 0, 0, 3);
        step(0, 1, 0, 0); outs("o7", 0, 0, 0); cnts("o7", 0, 0, 3);
        step(0, 0, 1, 0); outs("o8", 0, 0, 0); cnts("o8", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the next generation of our fixed 3-bit-state sequence FSMs. It watches a 1-bit input stream qualified by a valid strobe and compares it against a compile-time pattern of configurable length. It then pulses a registered match output, with overlapping or non-overlapping detection selected by parameter. It sits directly behind the serial input sampler and feeds the event logger.

## Interface

- `PAT_W`, default 4: pattern length in bits; legal range 2..32.
- `PATTERN`, default 4'b1011: target sequence; bit `PAT_W-1` is the oldest (first-received) bit and bit 0 is the newest.
- `OVERLAP`, default 1: 1 means overlapping detection; 0 means non-overlapping detection, where the window is cleared after a match.
- `CNT_W`, default 8: width of the match counter.

Ports (name, direction, width, meaning):

- `clock`, input, 1: the single clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `i` is sampled only when this is high.
- `i`, input, 1: serial data bit.
- `count_clr`, input, 1: synchronous clear of `match_count`.
- `out`, output, 1: registered match pulse.
- `match_count`, output, `CNT_W`: saturating count of matches. Present only with `SEQDET_COUNT_EN`.

## Operation

- Internal state:
  - `hist[PAT_W-1:0]` is the shift window.
  - `fill` counts valid bits held, range 0..`PAT_W`, width `$clog2(PAT_W+1)`.
- Reset, when `reset`=1 at an edge:
  - `hist`=0, `fill`=0, `out`=0, `match_count`=0.
  - Reset takes priority over every other input, including a pattern completing in the same cycle.
- Accepted sample, when `in_valid`=1:
  - The window shifts: `nhist = {hist[PAT_W-2:0], i}`.
  - `nfill = min(fill+1, PAT_W)`.
- Match condition: `nfill == PAT_W` and `nhist == PATTERN`. The `fill` check means that zeros left in `hist` after reset never produce a match.
- On a match:
  - `out` is set to 1 at that edge.
  - With `OVERLAP`=1, `hist` and `fill` update normally, so a suffix of the pattern can start the next match.
  - With `OVERLAP`=0, `fill` is set to 0 at that edge. The bits of the matched window are not reused.
- No sample, when `in_valid`=0:
  - `hist` and `fill` hold.
  - `out` is set to 0.
- `out` is never high for more than one consecutive cycle unless matches are completed on consecutive valid samples. That is only possible with `OVERLAP`=1 and a periodic pattern, for example all ones.
- Counter:
  - On a match, `match_count` increments and saturates at `2**CNT_W-1`.
  - `count_clr`=1 sets it to 0.
  - If `count_clr` and a match occur in the same cycle, the clear wins and the result is 0.

## Timing

- Latency: `out` rises at the same clock edge that captures the completing bit and is visible for the following cycle. That is one cycle after `i` is presented.
- `match_count` updates at the same edge as `out`.
- No handshake back-pressure: every cycle with `in_valid`=1 is consumed.
- Reset released mid-stream: detection restarts from an empty window, and the first possible match is `PAT_W` valid samples after release.

## Configuration

- `SEQDET_COUNT_EN` defined:
  - The `match_count` port and the saturating counter are built.
  - `count_clr` is functional.
- `SEQDET_COUNT_EN` undefined:
  - The `match_count` port is absent.
  - `count_clr` is still present on the port list but ignored.
  - Detection behaviour is identical in both builds.

## Structure

- Shared package `seqdet_pkg` holds:
  - `typedef enum logic {SEQDET_NONOVL=0, SEQDET_OVL=1} seqdet_mode_t`;
  - the constants `SEQDET_MAX_W`=32 and `SEQDET_MIN_W`=2;
  - an elaboration-time check function that rejects `PAT_W` outside the legal range.
- One sub-module, `seqdet_window`:
  - It holds the `hist` shift register and the `fill` saturating counter.
  - It takes a synchronous `flush` input, which the top level drives from non-overlapping matches.
- The top level holds the compare logic, the `out` register and the optional counter.

## Test plan

All cases use `PAT_W`=4 and `PATTERN`=4'b1011 unless noted; samples have `in_valid`=1.

1. Reset then stream 1,0,1,1,0,1,1 with `OVERLAP`=1 -> `out` pulses after samples 4 and 7; `match_count`=2.
2. Same stream with `OVERLAP`=0 -> `out` pulses after sample 4 only; `match_count`=1.
3. Stream 1,0 with `in_valid`=1, then three idle cycles with `in_valid`=0, then 1,1 with `in_valid`=1 -> `out` is 0 during the idles and pulses once after the final 1.
4. Stream 1,0,1, then `reset` asserted on the cycle that presents the final 1 -> `out`=0; after reset a fresh 1,0,1,1 is needed to match.
5. `PAT_W`=2, `PATTERN`=2'b11, `OVERLAP`=1, `CNT_W`=2, with 1 held for 6 samples -> `out` is high for 5 consecutive cycles; `match_count` saturates at 3.
6. `count_clr`=1 in the same cycle as a match -> `out`=1 and `match_count`=0. In a build without `SEQDET_COUNT_EN`, `out` matches the counted build cycle-for-cycle.
